mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles a transaction may spend in REQ+WAIT_R before abort (8-bit counter, 1..255).
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_ir_mem  in  16  instruction currently in MEM stage.
REQ-005 i_addr  in  32  effective address computed by EX.
REQ-006 i_wdata  in  32  store data.
REQ-007 i_flush  in  1  pipeline flush; blocks launch of a new transaction.
REQ-008 o_stall  out  1  holds the MEM stage and all earlier stages.
REQ-009 o_dmem_req / o_dmem_we  out  1 / 1  data memory request and write strobe.
REQ-010 o_dmem_addr / o_dmem_wdata  out  32 / 32  registered address (bits[1:0]=00) and write data.
REQ-011 i_dmem_gnt / i_dmem_rvalid  in  1 / 1  request accepted / read data valid.
REQ-012 i_dmem_rdata  in  32  read data.
REQ-013 o_rdata_r  out  32  captured load data, held until the next load completes.
REQ-014 o_done_r  out  1  one-cycle pulse when a transaction ends.

Function
REQ-015 Memory ops SHALL be decoded from i_ir_mem[15:11]: 01101 LDR imm, 01001 LDR literal (loads); 01100 STR imm (store); all else non-memory.
REQ-016 FSM states: IDLE, REQ, WAIT_R, DONE.
REQ-017 IDLE: a memory op with i_flush=0 SHALL latch i_addr (bits[1:0] cleared), i_wdata and load/store kind, then go to REQ next cycle.
REQ-018 REQ: o_dmem_req=1, o_dmem_we=1 for stores; address/data/we stable until i_dmem_gnt=1.
REQ-019 REQ with i_dmem_gnt: store goes to DONE; load goes to WAIT_R.
REQ-020 WAIT_R: i_dmem_rvalid SHALL load i_dmem_rdata into o_rdata_r and go to DONE; rvalid outside WAIT_R is ignored.
REQ-021 DONE: o_done_r=1 and o_stall=0 for exactly one cycle, then IDLE.
REQ-022 o_stall (combinational) SHALL be 1 in REQ and WAIT_R, and in IDLE when a memory op is decoded with i_flush=0; 0 otherwise.
REQ-023 Minimum latency: load 4 cycles IDLE->DONE (gnt in first REQ cycle, rvalid in first WAIT_R cycle); store 3 cycles.
REQ-024 i_flush SHALL only block a launch from IDLE; an in-flight transaction completes normally.
REQ-025 Back-to-back memory ops: the op following DONE is decoded in the immediately next IDLE cycle, with no bubble.

Reset
REQ-026 rst SHALL force IDLE, o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, o_rdata_r=0, o_done_r=0 and the timeout counter to 0.
REQ-027 rst mid-transaction SHALL abandon the transaction without a o_done_r pulse; a late i_dmem_rvalid is ignored.

Configuration
REQ-028 Macro MEM_ACCESS_TIMEOUT_EN present: counter increments each REQ/WAIT_R cycle; reaching TIMEOUT_CYCLES SHALL go to DONE, set o_rdata_r=0 on loads, and pulse output o_err_r (1 bit, reset 0) together with o_done_r.
REQ-029 MEM_ACCESS_TIMEOUT_EN absent: no counter and no o_err_r port; the FSM waits indefinitely.

Structure
REQ-030 Package mem_ctrl_pkg SHALL hold the state enum, the opcode match constants and the default TIMEOUT_CYCLES.
REQ-031 Sub-module mem_op_decode (combinational, i_ir_mem -> is_load, is_store) SHALL be instantiated once.

Verification
REQ-032 LDR imm, i_addr=0x1003, gnt in first REQ cycle, rvalid next cycle with 0xCAFEF00D -> o_dmem_addr=0x1000, o_rdata_r=0xCAFEF00D, o_stall high for 3 cycles, o_done_r pulse in cycle 4.
REQ-033 STR imm, i_wdata=0x12345678, gnt held low 5 cycles -> req/we/addr/wdata stable throughout, DONE one cycle after gnt, o_rdata_r unchanged.
REQ-034 ADD (0x1C00) in MEM -> o_stall=0, o_dmem_req never asserted.
REQ-035 LDR with i_flush=1 in IDLE -> no request, no stall; rst asserted in WAIT_R -> IDLE next cycle, no o_done_r, later rvalid ignored.
REQ-036 With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=8: gnt never asserted -> o_err_r and o_done_r pulse together after 8 REQ cycles, o_rdata_r=0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// mem_ctrl_pkg : shared types and constants for the MEM-stage access control
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] c_op_ldr_imm = 5'b01101;
    localparam logic [4:0] c_op_ldr_lit = 5'b01001;
    localparam logic [4:0] c_op_str_imm = 5'b01100;

    localparam int unsigned c_timeout_cycles_def = 255;

endpackage

`default_nettype wire

// File: rtl/mem_op_decode.sv
// ============================================================================
// mem_op_decode : classifies the MEM-stage instruction as load, store or other
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_op_decode
    import mem_ctrl_pkg::*;
(
    input  logic [15:0] i_ir_mem,
    output logic        o_is_load,
    output logic        o_is_store
);

    logic [4:0] w_op;
    logic       w_unused_bits;

    assign w_op          = i_ir_mem[15:11];
    assign w_unused_bits = ^i_ir_mem[10:0];

    assign o_is_load  = (w_op == c_op_ldr_imm) || (w_op == c_op_ldr_lit);
    assign o_is_store = (w_op == c_op_str_imm);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage data-memory handshake FSM with pipeline stall
//                   Optional abort timer: define MEM_ACCESS_TIMEOUT_EN
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles_def
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_ir_mem,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic [31:0] o_rdata_r,
    output logic        o_done_r
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    output logic        o_err_r
`endif
);

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        is_load_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_launch;
    logic        w_timeout_hit;

    mem_op_decode u_decode (
        .i_ir_mem   (i_ir_mem),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store)
    );

    assign w_launch = (state_q == ST_IDLE) && (w_is_load || w_is_store) && !i_flush;
    assign o_stall  = (state_q == ST_REQ) || (state_q == ST_WAIT_R) || w_launch;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    // Expiry only counts when the handshake did not complete this same cycle.
    assign w_timeout_hit = (cnt_q == c_timeout_last) &&
                           (((state_q == ST_REQ)    && !i_dmem_gnt) ||
                            ((state_q == ST_WAIT_R) && !i_dmem_rvalid));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= w_timeout_hit;
            if ((state_q == ST_REQ) || (state_q == ST_WAIT_R)) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= 8'd0;
            end
        end
    end

    assign o_err_r = err_q;
`else
    logic w_unused_cfg;

    assign w_unused_cfg  = ^c_timeout_last;
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_load_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_launch) begin
                        state_q   <= ST_REQ;
                        is_load_q <= w_is_load;
                        req_q     <= 1'b1;
                        we_q      <= w_is_store;
                        addr_q    <= {i_addr[31:2], 2'b00};
                        wdata_q   <= i_wdata;
                    end
                end
                ST_REQ: begin
                    if (i_dmem_gnt) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= is_load_q ? ST_WAIT_R : ST_DONE;
                        done_q  <= !is_load_q;
                    end
                end
                ST_WAIT_R: begin
                    if (i_dmem_rvalid) begin
                        rdata_q <= i_dmem_rdata;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // Abort overrides the wait; an aborted load reports zero data.
            if (w_timeout_hit) begin
                state_q <= ST_DONE;
                req_q   <= 1'b0;
                we_q    <= 1'b0;
                done_q  <= 1'b1;
                if (is_load_q) begin
                    rdata_q <= 32'd0;
                end
            end
        end
    end

    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_rdata_r    = rdata_q;
    assign o_done_r     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : scoreboard bench for mem_access_ctrl
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_ir_mem;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_flush;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_rdata_r;
    logic        o_done_r;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        o_err_r;
    localparam int unsigned c_tmo = 8;
`else
    localparam int unsigned c_tmo = 255;
`endif

    localparam logic [15:0] c_ldr_imm = 16'h6800;
    localparam logic [15:0] c_ldr_lit = 16'h4800;
    localparam logic [15:0] c_str_imm = 16'h6000;
    localparam logic [15:0] c_add     = 16'h1C00;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(c_tmo)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_ir_mem      (i_ir_mem),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .i_flush       (i_flush),
        .o_stall       (o_stall),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_gnt    (i_dmem_gnt),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_rdata_r     (o_rdata_r),
        .o_done_r      (o_done_r)
`ifdef MEM_ACCESS_TIMEOUT_EN
        ,
        .o_err_r       (o_err_r)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d, input logic er);
        exp_t x;
        x.addr  = a;
        x.rdata = d;
        x.err   = er;
        return x;
    endfunction

    // Completion monitor: every done pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!rst && o_done_r) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_addr", o_dmem_addr, e.addr);
                check_eq("sb_rdata", o_rdata_r, e.rdata);
                check_eq("sb_done_stall", {31'd0, o_stall}, 32'd0);
`ifdef MEM_ACCESS_TIMEOUT_EN
                check_eq("sb_err", {31'd0, o_err_r}, {31'd0, e.err});
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; i_ir_mem = 16'd0; i_addr = 32'd0; i_wdata = 32'd0; i_flush = 1'b0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
        repeat (3) tick();
        check_eq("rst_stall", {31'd0, o_stall}, 32'd0);
        check_eq("rst_req", {31'd0, o_dmem_req}, 32'd0);
        check_eq("rst_we", {31'd0, o_dmem_we}, 32'd0);
        check_eq("rst_addr", o_dmem_addr, 32'd0);
        check_eq("rst_wdata", o_dmem_wdata, 32'd0);
        check_eq("rst_rdata", o_rdata_r, 32'd0);
        check_eq("rst_done", {31'd0, o_done_r}, 32'd0);
        rst = 1'b0;
        tick();

        // Minimum-latency load
        i_ir_mem = c_ldr_imm; i_addr = 32'h1003; #1;
        check_eq("ld_idle_stall", {31'd0, o_stall}, 32'd1);
        sb_q.push_back(mk(32'h1000, 32'hCAFEF00D, 1'b0));
        tick(); i_dmem_gnt = 1'b1; #1;
        check_eq("ld_req", {31'd0, o_dmem_req}, 32'd1);
        check_eq("ld_we", {31'd0, o_dmem_we}, 32'd0);
        check_eq("ld_addr", o_dmem_addr, 32'h1000);
        check_eq("ld_req_stall", {31'd0, o_stall}, 32'd1);
        tick(); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEF00D; #1;
        check_eq("ld_wait_req", {31'd0, o_dmem_req}, 32'd0);
        check_eq("ld_wait_stall", {31'd0, o_stall}, 32'd1);
        check_eq("ld_wait_done", {31'd0, o_done_r}, 32'd0);
        tick(); i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0; #1;
        check_eq("ld_done", {31'd0, o_done_r}, 32'd1);
        check_eq("ld_done_stall", {31'd0, o_stall}, 32'd0);
        check_eq("ld_rdata", o_rdata_r, 32'hCAFEF00D);
        i_ir_mem = 16'd0;
        tick();
        check_eq("ld_done_1cyc", {31'd0, o_done_r}, 32'd0);

        // Store with delayed grant; flush mid-flight must not abort it
        i_ir_mem = c_str_imm; i_addr = 32'h2006; i_wdata = 32'h12345678; #1;
        check_eq("st_idle_stall", {31'd0, o_stall}, 32'd1);
        sb_q.push_back(mk(32'h2004, 32'hCAFEF00D, 1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) i_flush = 1'b1;
            #1;
            check_eq("st_hold_req", {31'd0, o_dmem_req}, 32'd1);
            check_eq("st_hold_we", {31'd0, o_dmem_we}, 32'd1);
            check_eq("st_hold_addr", o_dmem_addr, 32'h2004);
            check_eq("st_hold_wdata", o_dmem_wdata, 32'h12345678);
            check_eq("st_hold_stall", {31'd0, o_stall}, 32'd1);
        end
        tick(); i_dmem_gnt = 1'b1; #1;
        check_eq("st_gnt_req", {31'd0, o_dmem_req}, 32'd1);
        tick(); i_dmem_gnt = 1'b0; i_flush = 1'b0; #1;
        check_eq("st_done", {31'd0, o_done_r}, 32'd1);
        check_eq("st_done_req", {31'd0, o_dmem_req}, 32'd0);
        check_eq("st_rdata_kept", o_rdata_r, 32'hCAFEF00D);
        i_ir_mem = 16'd0;
        tick();

        // Non-memory instruction
        i_ir_mem = c_add;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("add_stall", {31'd0, o_stall}, 32'd0);
            check_eq("add_req", {31'd0, o_dmem_req}, 32'd0);
            tick();
        end

        // Flushed load never launches
        i_ir_mem = c_ldr_lit; i_flush = 1'b1; #1;
        check_eq("flush_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check_eq("flush_req", {31'd0, o_dmem_req}, 32'd0);
        tick();
        check_eq("flush_req2", {31'd0, o_dmem_req}, 32'd0);
        i_flush = 1'b0; i_ir_mem = 16'd0;
        tick();

        // LDR literal with stray rvalid in REQ, then a store launched right after DONE
        i_ir_mem = c_ldr_lit; i_addr = 32'h30; #1;
        sb_q.push_back(mk(32'h30, 32'h11112222, 1'b0));
        tick(); i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEADBEEF; #1;
        check_eq("b2b_req", {31'd0, o_dmem_req}, 32'd1);
        tick(); i_dmem_rvalid = 1'b0; i_dmem_gnt = 1'b1; #1;
        check_eq("b2b_stray_done", {31'd0, o_done_r}, 32'd0);
        check_eq("b2b_req2", {31'd0, o_dmem_req}, 32'd1);
        tick(); i_dmem_gnt = 1'b0; #1;
        check_eq("b2b_stray_rdata", o_rdata_r, 32'hCAFEF00D);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h11112222;
        tick(); i_dmem_rvalid = 1'b0;
        i_ir_mem = c_str_imm; i_addr = 32'h44; i_wdata = 32'h0000AA55; #1;
        check_eq("b2b_done", {31'd0, o_done_r}, 32'd1);
        sb_q.push_back(mk(32'h44, 32'h11112222, 1'b0));
        tick();
        check_eq("b2b_idle_stall", {31'd0, o_stall}, 32'd1);
        tick(); i_dmem_gnt = 1'b1; #1;
        check_eq("b2b_st_we", {31'd0, o_dmem_we}, 32'd1);
        check_eq("b2b_st_addr", o_dmem_addr, 32'h44);
        tick(); i_dmem_gnt = 1'b0; #1;
        check_eq("b2b_st_done", {31'd0, o_done_r}, 32'd1);
        i_ir_mem = 16'd0;
        tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Grant never arrives: abort after TIMEOUT_CYCLES request cycles
        i_ir_mem = c_ldr_imm; i_addr = 32'h60; #1;
        sb_q.push_back(mk(32'h60, 32'd0, 1'b1));
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("tmo_req", {31'd0, o_dmem_req}, 32'd1);
            check_eq("tmo_no_done", {31'd0, o_done_r}, 32'd0);
        end
        tick(); #1;
        check_eq("tmo_done", {31'd0, o_done_r}, 32'd1);
        check_eq("tmo_err", {31'd0, o_err_r}, 32'd1);
        check_eq("tmo_rdata", o_rdata_r, 32'd0);
        i_ir_mem = 16'd0;
        tick();
        check_eq("tmo_err_clr", {31'd0, o_err_r}, 32'd0);
`endif

        // Reset while waiting for read data abandons the load
        i_ir_mem = c_ldr_imm; i_addr = 32'h50; #1;
        tick(); i_dmem_gnt = 1'b1; #1;
        tick(); i_dmem_gnt = 1'b0; #1;
        check_eq("rstw_stall", {31'd0, o_stall}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; i_ir_mem = 16'd0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hBAD0BAD0; #1;
        check_eq("rstw_done", {31'd0, o_done_r}, 32'd0);
        check_eq("rstw_req", {31'd0, o_dmem_req}, 32'd0);
        check_eq("rstw_stall2", {31'd0, o_stall}, 32'd0);
        check_eq("rstw_rdata", o_rdata_r, 32'd0);
        tick(); i_dmem_rvalid = 1'b0; #1;
        check_eq("rstw_late_done", {31'd0, o_done_r}, 32'd0);
        check_eq("rstw_late_rdata", o_rdata_r, 32'd0);
        repeat (2) tick();

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
